// File: rtl/hazard_pkg.sv
// Shared decode constants, instruction classes and latency values for the hazard unit.
// Tuse/Tnew are 2-bit; T_NONE marks an operand field that is not read.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [3:0] {
    CALC_R, CALC_I, LOAD, STORE, BRANCH, JAL, JR, MD, MF, MT, NOP
  } iclass_t;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef logic [1:0] tval_t;
  // Larger than any Tnew, so an unread field can never raise a hazard.
  localparam tval_t T_NONE = 2'd3;

  // div/divu have funct bit 1 set, mult/multu do not.
  function automatic logic [3:0] md_latency(logic [5:0] fn);
    return fn[1] ? DIV_LAT : MULT_LAT;
  endfunction

  function automatic tval_t tnew_at_m(tval_t tnew_e);
    return (tnew_e == 2'd0) ? 2'd0 : tval_t'(tnew_e - 2'd1);
  endfunction

  function automatic logic src_hazard(logic [4:0] src, tval_t tuse,
                                      logic [4:0] dst, tval_t tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_unit_instr_class.sv
// Combinational instruction decoder: IR -> class, sources, destination, Tuse and Tnew (E-relative).
// With HAZARD_MD_EN undefined the mult/div/HI/LO group decodes as NOP.
module instr_class
  import hazard_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  cls,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dst,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [1:0]  tnew
);

  logic [5:0] op;
  logic [5:0] fn;
  iclass_t    c;

  assign op  = ir[31:26];
  assign fn  = ir[5:0];
  assign rs  = ir[25:21];
  assign rt  = ir[20:16];
  assign cls = c;

  always_comb begin
    c = NOP;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU: c = CALC_R;
          FN_JR:            c = JR;
`ifdef HAZARD_MD_EN
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: c = MD;
          FN_MFHI, FN_MFLO: c = MF;
          FN_MTHI, FN_MTLO: c = MT;
`endif
          default:          c = NOP;
        endcase
      end
      OP_ORI, OP_LUI: c = CALC_I;
      OP_LW:          c = LOAD;
      OP_SW:          c = STORE;
      OP_BEQ:         c = BRANCH;
      OP_JAL:         c = JAL;
      default:        c = NOP;
    endcase
  end

  always_comb begin
    dst     = 5'd0;
    tuse_rs = T_NONE;
    tuse_rt = T_NONE;
    tnew    = 2'd0;
    case (c)
      CALC_R: begin
        dst = ir[15:11]; tuse_rs = 2'd1; tuse_rt = 2'd1; tnew = 2'd1;
      end
      CALC_I: begin
        // lui has no register source.
        dst = rt; tuse_rs = (op == OP_LUI) ? T_NONE : 2'd1; tnew = 2'd1;
      end
      LOAD:   begin dst = rt; tuse_rs = 2'd1; tnew = 2'd2; end
      STORE:  begin tuse_rs = 2'd1; tuse_rt = 2'd2; end
      BRANCH: begin tuse_rs = 2'd0; tuse_rt = 2'd0; end
      JR:     tuse_rs = 2'd0;
      JAL:    dst = 5'd31;
      MD:     begin tuse_rs = 2'd1; tuse_rt = 2'd1; end
      MF:     begin dst = ir[15:11]; tnew = 2'd1; end
      MT:     tuse_rs = 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall / E-bubble generation for the five-stage MIPS core, with the mult/div busy counter.
// Mult/div support is built only when HAZARD_MD_EN is defined.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  output logic        stall,
  output logic        clr_E,
  output logic        md_start,
  output logic        md_busy
);

  logic [3:0] cls_d, cls_e, cls_m_unused;
  logic [4:0] rs_d, rt_d, dst_d_unused;
  logic [4:0] rs_e_unused, rt_e_unused, dst_e;
  logic [4:0] rs_m_unused, rt_m_unused, dst_m;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d_unused;
  logic [1:0] tuse_rs_e_unused, tuse_rt_e_unused, tnew_e;
  logic [1:0] tuse_rs_m_unused, tuse_rt_m_unused, tnew_m_raw;
  tval_t      tnew_m;
  logic       data_stall;
  logic       md_stall;

  instr_class u_dec_d (
    .ir(IR_D), .cls(cls_d), .rs(rs_d), .rt(rt_d), .dst(dst_d_unused),
    .tuse_rs(tuse_rs_d), .tuse_rt(tuse_rt_d), .tnew(tnew_d_unused)
  );

  instr_class u_dec_e (
    .ir(IR_E), .cls(cls_e), .rs(rs_e_unused), .rt(rt_e_unused), .dst(dst_e),
    .tuse_rs(tuse_rs_e_unused), .tuse_rt(tuse_rt_e_unused), .tnew(tnew_e)
  );

  instr_class u_dec_m (
    .ir(IR_M), .cls(cls_m_unused), .rs(rs_m_unused), .rt(rt_m_unused), .dst(dst_m),
    .tuse_rs(tuse_rs_m_unused), .tuse_rt(tuse_rt_m_unused), .tnew(tnew_m_raw)
  );

  assign tnew_m = tnew_at_m(tnew_m_raw);

  assign data_stall = src_hazard(rs_d, tuse_rs_d, dst_e, tnew_e)
                    | src_hazard(rt_d, tuse_rt_d, dst_e, tnew_e)
                    | src_hazard(rs_d, tuse_rs_d, dst_m, tnew_m)
                    | src_hazard(rt_d, tuse_rt_d, dst_m, tnew_m);

`ifdef HAZARD_MD_EN
  logic [3:0] md_cnt;

  assign md_start = (cls_e == MD);
  assign md_busy  = (md_cnt != 4'd0);
  assign md_stall = (cls_d inside {MD, MF, MT}) && (md_busy || md_start);

  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= 4'd0;
    else if (md_start)
      md_cnt <= md_latency(IR_E[5:0]);
    else if (md_busy)
      md_cnt <= md_cnt - 4'd1;
  end
`else
  logic md_unused;

  assign md_start  = 1'b0;
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
  assign md_unused = ^{clk, reset, cls_d, cls_e};
`endif

  assign stall = data_stall | md_stall;
  assign clr_E = stall;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized pipeline-driven bench for hazard_unit with a behavioural reference model.
// Works for both builds; the HAZARD_MD_EN macro selects the expected mult/div behaviour.
module tb_hazard_unit;

  typedef enum int {
    K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR,
    K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_NOP, K_OTHER
  } kind_t;
  localparam int NKIND = 19;

`ifdef HAZARD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct {
    kind_t       k;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] w;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir_d = 32'd0, ir_e = 32'd0, ir_m = 32'd0;
  logic        stall, clr_e, md_start, md_busy;

  hazard_unit dut (
    .clk(clk), .reset(reset), .IR_D(ir_d), .IR_E(ir_e), .IR_M(ir_m),
    .stall(stall), .clr_E(clr_e), .md_start(md_start), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  rec_t sd, se, sm, nop_r;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ready = 0;
  bit   chk_en = 1'b0;
  bit   m_stall = 1'b0;

  function automatic rec_t mk(kind_t k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    rec_t r;
    logic [15:0] imm;
    imm = 16'($urandom);
    r.k = k; r.rs = rs; r.rt = rt; r.rd = rd;
    case (k)
      K_ADDU:  r.w = {6'h00, rs, rt, rd, 5'd0, 6'h21};
      K_SUBU:  r.w = {6'h00, rs, rt, rd, 5'd0, 6'h23};
      K_ORI:   r.w = {6'h0d, rs, rt, imm};
      K_LUI:   r.w = {6'h0f, rs, rt, imm};
      K_LW:    r.w = {6'h23, rs, rt, imm};
      K_SW:    r.w = {6'h2b, rs, rt, imm};
      K_BEQ:   r.w = {6'h04, rs, rt, imm};
      K_JAL:   r.w = {6'h03, rs, rt, imm};
      K_JR:    r.w = {6'h00, rs, 15'd0, 6'h08};
      K_MULT:  r.w = {6'h00, rs, rt, 10'd0, 6'h18};
      K_MULTU: r.w = {6'h00, rs, rt, 10'd0, 6'h19};
      K_DIV:   r.w = {6'h00, rs, rt, 10'd0, 6'h1a};
      K_DIVU:  r.w = {6'h00, rs, rt, 10'd0, 6'h1b};
      K_MFHI:  r.w = {6'h00, 10'd0, rd, 5'd0, 6'h10};
      K_MFLO:  r.w = {6'h00, 10'd0, rd, 5'd0, 6'h12};
      K_MTHI:  r.w = {6'h00, rs, 15'd0, 6'h11};
      K_MTLO:  r.w = {6'h00, rs, 15'd0, 6'h13};
      K_OTHER: r.w = {6'h08, rs, rt, imm};
      default: r.w = 32'd0;
    endcase
    return r;
  endfunction

  function automatic rec_t rnd();
    return mk(kind_t'($urandom_range(0, NKIND - 1)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
  endfunction

  // Reference rules, stated per instruction kind.
  function automatic bit is_mult_class(kind_t k);
    return MD_EN && (k inside {K_MULT, K_MULTU, K_DIV, K_DIVU});
  endfunction

  function automatic bit is_md_family(kind_t k);
    return MD_EN && (k inside {K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO});
  endfunction

  function automatic int dest_of(rec_t r);
    if (r.k inside {K_ADDU, K_SUBU}) return r.rd;
    if (r.k inside {K_MFHI, K_MFLO}) return MD_EN ? int'(r.rd) : 0;
    if (r.k inside {K_ORI, K_LUI, K_LW}) return r.rt;
    if (r.k == K_JAL) return 31;
    return 0;
  endfunction

  function automatic int tuse_rs(kind_t k);
    if (k inside {K_BEQ, K_JR}) return 0;
    if (k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW}) return 1;
    if (is_md_family(k) && !(k inside {K_MFHI, K_MFLO})) return 1;
    return 99;
  endfunction

  function automatic int tuse_rt(kind_t k);
    if (k == K_BEQ) return 0;
    if (k inside {K_ADDU, K_SUBU}) return 1;
    if (is_mult_class(k)) return 1;
    if (k == K_SW) return 2;
    return 99;
  endfunction

  function automatic int tnew_e(kind_t k);
    if (k == K_LW) return 2;
    if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI}) return 1;
    if (is_md_family(k) && (k inside {K_MFHI, K_MFLO})) return 1;
    return 0;
  endfunction

  function automatic int tnew_m(kind_t k);
    return (k == K_LW) ? 1 : 0;
  endfunction

  function automatic bit reads_hazard(int src, int tuse);
    int de, dm;
    de = dest_of(se);
    dm = dest_of(sm);
    if (src == 0) return 1'b0;
    return (src == de && tuse < tnew_e(se.k)) || (src == dm && tuse < tnew_m(sm.k));
  endfunction

  function automatic bit model_start();
    return is_mult_class(se.k);
  endfunction

  function automatic bit model_busy();
    return cyc < ready;
  endfunction

  function automatic bit model_stall();
    bit data;
    data = reads_hazard(sd.rs, tuse_rs(sd.k)) || reads_hazard(sd.rt, tuse_rt(sd.k));
    return data || (is_md_family(sd.k) && (model_busy() || model_start()));
  endfunction

  // Result availability tracked as an absolute cycle number.
  always @(posedge clk) begin
    if (reset)
      ready = 0;
    else if (model_start())
      ready = cyc + ((se.k inside {K_DIV, K_DIVU}) ? 10 : 5) + 1;
    cyc = cyc + 1;
  end

  task automatic check(string name, logic [3:0] got, logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    m_stall = model_stall();
    if (chk_en) begin
      check("stall", {3'b0, stall}, {3'b0, m_stall});
      check("clr_E", {3'b0, clr_e}, {3'b0, m_stall});
      check("md_start", {3'b0, md_start}, {3'b0, model_start()});
      check("md_busy", {3'b0, md_busy}, {3'b0, model_busy()});
    end
  end

  task automatic step(rec_t d, rec_t e, rec_t m, logic rst);
    @(posedge clk);
    #1;
    sd = d; se = e; sm = m;
    ir_d = d.w; ir_e = e.w; ir_m = m.w;
    reset = rst;
  endtask

  // Literal {stall, clr_E, md_start, md_busy} expectation for the current cycle.
  task automatic expect_now(string name, logic [3:0] exp);
    @(negedge clk);
    #1;
    check(name, {stall, clr_e, md_start, md_busy}, exp);
  endtask

  initial begin
    rec_t mflo, mult_r, div_r, nd, ne, nm;
    bit rst;
    nop_r = mk(K_NOP, 5'd0, 5'd0, 5'd0);
    sd = nop_r; se = nop_r; sm = nop_r;
    mflo   = mk(K_MFLO, 5'd0, 5'd0, 5'd4);
    mult_r = mk(K_MULT, 5'd5, 5'd6, 5'd0);
    div_r  = mk(K_DIV, 5'd5, 5'd6, 5'd0);

    step(nop_r, nop_r, nop_r, 1'b1);
    step(nop_r, nop_r, nop_r, 1'b1);
    chk_en = 1'b1;
    expect_now("reset_state", 4'b0000);

    step(mk(K_ADDU, 5'd1, 5'd3, 5'd2), mk(K_LW, 5'd7, 5'd1, 5'd0), nop_r, 1'b0);
    expect_now("lw_use_E", 4'b1100);
    step(mk(K_ADDU, 5'd1, 5'd3, 5'd2), nop_r, mk(K_LW, 5'd7, 5'd1, 5'd0), 1'b0);
    expect_now("lw_use_M", 4'b0000);

    step(mk(K_BEQ, 5'd1, 5'd2, 5'd0), mk(K_ADDU, 5'd3, 5'd3, 5'd1), nop_r, 1'b0);
    expect_now("beq_E", 4'b1100);
    step(mk(K_BEQ, 5'd1, 5'd2, 5'd0), nop_r, mk(K_ADDU, 5'd3, 5'd3, 5'd1), 1'b0);
    expect_now("beq_M", 4'b0000);

    step(mk(K_ADDU, 5'd0, 5'd0, 5'd2), mk(K_LW, 5'd1, 5'd0, 5'd0), nop_r, 1'b0);
    expect_now("reg0", 4'b0000);
    step(mk(K_SW, 5'd2, 5'd1, 5'd0), mk(K_ADDU, 5'd3, 5'd3, 5'd1), nop_r, 1'b0);
    expect_now("sw_rt", 4'b0000);

    step(mflo, mult_r, nop_r, 1'b0);
    expect_now("mult_t", MD_EN ? 4'b1110 : 4'b0000);
    for (int i = 1; i <= 5; i++) begin
      step(mflo, nop_r, (i == 1) ? mult_r : nop_r, 1'b0);
      expect_now("mult_busy", MD_EN ? 4'b1101 : 4'b0000);
    end
    step(mflo, nop_r, nop_r, 1'b0);
    expect_now("mult_done", 4'b0000);

    step(mflo, div_r, nop_r, 1'b0);
    expect_now("div_t", MD_EN ? 4'b1110 : 4'b0000);
    for (int i = 1; i <= 10; i++) begin
      step(mflo, nop_r, nop_r, 1'b0);
      expect_now("div_busy", MD_EN ? 4'b1101 : 4'b0000);
    end
    step(mflo, nop_r, nop_r, 1'b0);
    expect_now("div_done", 4'b0000);

    // div loads 10; three cycles later the counter holds 7 when reset hits.
    step(mflo, div_r, nop_r, 1'b0);
    for (int i = 1; i <= 3; i++) step(mflo, nop_r, nop_r, 1'b0);
    step(mflo, nop_r, nop_r, 1'b1);
    expect_now("reset_mid", MD_EN ? 4'b1101 : 4'b0000);
    step(mflo, nop_r, nop_r, 1'b0);
    expect_now("after_reset", 4'b0000);

    step(rnd(), nop_r, nop_r, 1'b0);
    repeat (3000) begin
      @(negedge clk);
      #1;
      nm = se;
      if (m_stall) begin
        ne = nop_r;
        nd = sd;
      end else begin
        ne = sd;
        nd = rnd();
      end
      rst = ($urandom_range(0, 99) == 0);
      step(nd, ne, nm, rst);
    end
    step(nop_r, nop_r, nop_r, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
